// File: rtl/fdtd_e_update.sv
// 1-D FDTD electric-field update sequencer: reads H[i-1], H[i] and E[i], and
// writes E[i] back through a one-stage pipeline. Cell 0 is the fixed boundary.
module fdtd_e_update #(
  parameter int FDTD_DATA_WIDTH   = 32,
  parameter int BUFFER_ADDR_WIDTH = 6,
  parameter int FRAC_BITS         = 16
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         start,
  input  logic [BUFFER_ADDR_WIDTH-1:0] last_idx,
  input  logic [FDTD_DATA_WIDTH-1:0]   coef,
  output logic                         busy,
  output logic                         done,
  output logic                         e_en,
  output logic                         e_wren,
  output logic [BUFFER_ADDR_WIDTH-1:0] e_addr_a,
  output logic [FDTD_DATA_WIDTH-1:0]   e_din,
  output logic                         e_rden,
  output logic [BUFFER_ADDR_WIDTH-1:0] e_addr_b,
  input  logic [FDTD_DATA_WIDTH-1:0]   e_dout,
  output logic                         h_rden,
  output logic [BUFFER_ADDR_WIDTH-1:0] h_addr,
  input  logic [FDTD_DATA_WIDTH-1:0]   h_dout
);

  // state  | meaning
  // IDLE   | waiting for start
  // PRIME  | fetch H[0] into h_prev
  // RUN    | read E[idx]/H[idx], stage-1 capture, write of idx-1
  // DRAIN  | final write of last_idx
  // DONE   | one-cycle done pulse

  localparam int W = FDTD_DATA_WIDTH;
  localparam int A = BUFFER_ADDR_WIDTH;
  localparam logic [A-1:0] ADDR_ONE = A'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t              state_q;
  logic [A-1:0]        idx_q;
  logic [A-1:0]        last_q;
  logic [A-1:0]        rd_addr_q;
  logic signed [W-1:0] coef_q;
  logic [W-1:0]        h_prev_q;
  logic                s1_valid_q;
  logic [A-1:0]        s1_addr_q;
  logic signed [W-1:0] s1_e_q;
  logic signed [W:0]   s1_diff_q;
  logic                busy_q;
  logic                done_q;
  logic                e_rden_q;
  logic                h_rden_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      last_q     <= '0;
      rd_addr_q  <= '0;
      coef_q     <= '0;
      h_prev_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_e_q     <= '0;
      s1_diff_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      e_rden_q   <= 1'b0;
      h_rden_q   <= 1'b0;
    end else begin
      s1_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (last_idx == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              last_q    <= last_idx;
              coef_q    <= coef;
              state_q   <= ST_PRIME;
              busy_q    <= 1'b1;
              h_rden_q  <= 1'b1;
              rd_addr_q <= '0;
            end
          end
        end
        ST_PRIME: begin
          h_prev_q  <= h_dout;
          idx_q     <= ADDR_ONE;
          rd_addr_q <= ADDR_ONE;
          e_rden_q  <= 1'b1;
          state_q   <= ST_RUN;
        end
        ST_RUN: begin
          s1_valid_q <= 1'b1;
          s1_addr_q  <= idx_q;
          s1_e_q     <= e_dout;
          s1_diff_q  <= {h_prev_q[W-1], h_prev_q} - {h_dout[W-1], h_dout};
          h_prev_q   <= h_dout;
          // Equality stop keeps idx from wrapping when last_idx is all ones.
          if (idx_q == last_q) begin
            state_q   <= ST_DRAIN;
            e_rden_q  <= 1'b0;
            h_rden_q  <= 1'b0;
            rd_addr_q <= '0;
          end else begin
            idx_q     <= idx_q + ADDR_ONE;
            rd_addr_q <= idx_q + ADDR_ONE;
          end
        end
        ST_DRAIN: begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          e_rden_q <= 1'b0;
          h_rden_q <= 1'b0;
        end
      endcase
    end
  end

  // Full-precision product and sum; saturation happens only at the very end.
  logic signed [2*W:0]   prod;
  logic signed [2*W:0]   shifted;
  logic signed [2*W+1:0] sum;
  logic                  ovf;

  assign prod    = (2*W+1)'(coef_q) * (2*W+1)'(s1_diff_q);
  assign shifted = prod >>> FRAC_BITS;
  assign sum     = (2*W+2)'(s1_e_q) + (2*W+2)'(shifted);
  assign ovf     = !((&sum[2*W+1:W-1]) || !(|sum[2*W+1:W-1]));

  assign e_din    = ovf ? {sum[2*W+1], {(W-1){~sum[2*W+1]}}} : sum[W-1:0];
  assign e_wren   = s1_valid_q;
  assign e_en     = s1_valid_q;
  assign e_addr_a = s1_addr_q;
  assign e_rden   = e_rden_q;
  assign e_addr_b = rd_addr_q;
  assign h_rden   = h_rden_q;
  assign h_addr   = rd_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_fdtd_e_update.sv
// Bench for fdtd_e_update: behavioural E/H RAMs, table vectors, corner sweeps
// and randomized sweeps checked against a plain-arithmetic update model.
module tb_fdtd_e_update;

  logic        CLK;
  logic        RST_N;
  logic        start;
  logic [5:0]  last_idx;
  logic [31:0] coef;
  logic        busy, done, e_en, e_wren, e_rden, h_rden;
  logic [5:0]  e_addr_a, e_addr_b, h_addr;
  logic [31:0] e_din, e_dout, h_dout;

  fdtd_e_update #(
    .FDTD_DATA_WIDTH(32),
    .BUFFER_ADDR_WIDTH(6),
    .FRAC_BITS(16)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .last_idx(last_idx), .coef(coef),
    .busy(busy), .done(done), .e_en(e_en), .e_wren(e_wren), .e_addr_a(e_addr_a),
    .e_din(e_din), .e_rden(e_rden), .e_addr_b(e_addr_b), .e_dout(e_dout),
    .h_rden(h_rden), .h_addr(h_addr), .h_dout(h_dout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [31:0] e_mem  [64];
  logic [31:0] e_init [64];
  logic [31:0] e_exp  [64];
  logic [31:0] h_mem  [64];
  logic        load;

  always @(posedge CLK) begin
    if (load) begin
      for (int i = 0; i < 64; i++) e_mem[i] <= e_init[i];
    end else if (e_wren) begin
      e_mem[e_addr_a] <= e_din;
    end
  end

  assign e_dout = e_mem[e_addr_b];
  assign h_dout = h_mem[h_addr];

  int n_checks = 0;
  int n_fail   = 0;
  int wr_q[$];
  int h_rd_cnt, e_rd_cnt, en_err;

  always @(negedge CLK) begin
    if (RST_N) begin
      if (e_wren) wr_q.push_back(int'(e_addr_a));
      if (h_rden) h_rd_cnt++;
      if (e_rden) e_rd_cnt++;
      if (e_en !== e_wren) en_err++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // E[i] + floor(coef*(H[i-1]-H[i]) / 2^16), clamped to the 32-bit signed range.
  function automatic logic [31:0] ref_cell(input logic [31:0] e, input logic [31:0] hp,
                                           input logic [31:0] h, input logic [31:0] c);
    longint diff, p, s;
    diff = longint'($signed(hp)) - longint'($signed(h));
    p    = longint'($signed(c)) * diff;
    s    = longint'($signed(e)) + (p >>> 16);
    if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  task automatic load_mems();
    @(negedge CLK);
    load = 1'b1;
    @(negedge CLK);
    load = 1'b0;
  endtask

  task automatic sweep(input int L, input logic [31:0] c, input bit disturb, input string tag);
    int k, busy_cnt, ord_err, exp_done;
    for (int i = 0; i < 64; i++) e_exp[i] = e_init[i];
    for (int i = 1; i <= L; i++) e_exp[i] = ref_cell(e_init[i], h_mem[i-1], h_mem[i], c);
    load_mems();
    wr_q.delete();
    h_rd_cnt = 0;
    e_rd_cnt = 0;
    en_err   = 0;
    busy_cnt = 0;
    start    = 1'b1;
    last_idx = 6'(L);
    coef     = c;
    @(negedge CLK);
    start = 1'b0;
    k = 0;
    while (!done && k < 300) begin
      if (busy) busy_cnt++;
      if (disturb && k == 5) begin
        start    = 1'b1;
        coef     = $urandom;
        last_idx = 6'($urandom_range(0, 63));
      end
      if (disturb && k == 6) start = 1'b0;
      @(negedge CLK);
      k++;
    end
    exp_done = (L == 0) ? 0 : L + 2;
    check({tag, " done cycle"}, 64'(k), 64'(exp_done));
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_done));
    @(negedge CLK);
    check({tag, " done one-cycle"}, 64'(done), 64'(0));
    check({tag, " write count"}, 64'(wr_q.size()), 64'(L));
    ord_err = 0;
    foreach (wr_q[j]) if (wr_q[j] != j + 1) ord_err++;
    check({tag, " write order"}, 64'(ord_err), 64'(0));
    check({tag, " h reads"}, 64'(h_rd_cnt), 64'((L == 0) ? 0 : L + 1));
    check({tag, " e reads"}, 64'(e_rd_cnt), 64'(L));
    check({tag, " e_en vs e_wren"}, 64'(en_err), 64'(0));
    for (int i = 0; i < 64; i++)
      check($sformatf("%s E[%0d]", tag, i), 64'(e_mem[i]), 64'(e_exp[i]));
  endtask

  typedef struct {
    logic [31:0] e1;
    logic [31:0] h0;
    logic [31:0] h1;
    logic [31:0] c;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int done_seen;
    logic [31:0] r, r2;
    RST_N    = 1'b0;
    start    = 1'b0;
    last_idx = '0;
    coef     = '0;
    load     = 1'b0;
    for (int i = 0; i < 64; i++) begin
      e_init[i] = '0;
      h_mem[i]  = '0;
    end
    #3;
    check("reset outputs", 64'({busy, done, e_en, e_wren, e_addr_a, e_din, e_rden,
                                e_addr_b, h_rden, h_addr}), 64'(0));
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    vecs[0] = '{32'h0000_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_8000, 32'hFFFF_8000};
    vecs[1] = '{32'h7FFF_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0001_0000, 32'h7FFF_FFFF};
    vecs[2] = '{32'h8001_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0001_0000, 32'h8000_0000};
    vecs[3] = '{32'h0000_1000, 32'h0003_0000, 32'h0001_0000, 32'h0002_0000, 32'h0004_1000};
    vecs[4] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[5] = '{32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'h1234_5678};
    vecs[6] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 64; i++) begin
        e_init[i] = 32'hDEAD_0000 | 32'(i);
        h_mem[i]  = '0;
      end
      e_init[1] = vecs[v].e1;
      h_mem[0]  = vecs[v].h0;
      h_mem[1]  = vecs[v].h1;
      sweep(1, vecs[v].c, 1'b0, $sformatf("vec%0d", v));
      check($sformatf("vec%0d E[1] table", v), 64'(e_mem[1]), 64'(vecs[v].exp));
      check($sformatf("vec%0d E[0] untouched", v), 64'(e_mem[0]), 64'(32'hDEAD_0000));
    end

    // last_idx == 0: straight to done, no RAM traffic
    for (int i = 0; i < 64; i++) e_init[i] = 32'h5A5A_0000 | 32'(i);
    sweep(0, 32'h0001_0000, 1'b0, "zero");

    // Full ramp sweep, then again with start/coef/last_idx disturbed mid-sweep
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 64; i++) begin
        e_init[i] = '0;
        h_mem[i]  = 32'(i) << 16;
      end
      sweep(63, 32'h0001_0000, pass == 1, pass == 1 ? "ramp_dist" : "ramp");
      check(pass == 1 ? "ramp_dist E[63]" : "ramp E[63]", 64'(e_mem[63]), 64'(32'hFFFF_0000));
    end

    // Asynchronous reset at RUN idx=10
    for (int i = 0; i < 64; i++) begin
      e_init[i] = '0;
      h_mem[i]  = 32'(i) << 16;
    end
    load_mems();
    start    = 1'b1;
    last_idx = 6'd40;
    coef     = 32'h0001_0000;
    @(negedge CLK);
    start = 1'b0;
    repeat (10) @(negedge CLK);
    check("pre-abort busy", 64'(busy), 64'(1));
    check("pre-abort read addr", 64'(e_addr_b), 64'(10));
    #2 RST_N = 1'b0;
    #1;
    check("abort outputs", 64'({busy, done, e_en, e_wren, e_addr_a, e_din, e_rden,
                                e_addr_b, h_rden, h_addr}), 64'(0));
    done_seen = 0;
    repeat (3) begin
      @(negedge CLK);
      if (done) done_seen++;
    end
    RST_N = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      if (done) done_seen++;
    end
    check("abort no done", 64'(done_seen), 64'(0));
    check("abort idle", 64'(busy), 64'(0));
    for (int i = 0; i < 64; i++) begin
      e_init[i] = 32'(i) << 8;
      h_mem[i]  = 32'(i * i) << 12;
    end
    sweep(63, 32'h0000_C000, 1'b0, "post_reset");

    // Randomized sweeps
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 64; i++) begin
        r = $urandom;
        e_init[i] = {{8{r[23]}}, r[23:0]};
        r = $urandom;
        h_mem[i]  = (t == 5) ? r : {{8{r[23]}}, r[23:0]};
      end
      r2 = $urandom;
      r  = (t >= 4) ? r2 : {{14{r2[17]}}, r2[17:0]};
      sweep($urandom_range(1, 63), r, 1'b0, $sformatf("rand%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
